bpm_smoother: RTL and testbench

//  Downstream consumer of the BPM calculator's output handshake (bpm_value/bpm_valid/bpm_copied).

---
 rtl/bpm_smoother.sv | 196 +++++++++++++++++++
 tb/tb_bpm_smoother.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bpm_smoother.sv
// bpm_smoother
//   Takes instantaneous BPM readings from the BPM calculator handshake, drops
//   readings outside [BPM_MIN, BPM_MAX], keeps a 2**DEPTH_LOG2-entry moving
//   average and offers the smoothed value to the display/host over valid/ack.
//   Raises no_pulse after TIMEOUT_TICKS en ticks without an accepted reading.
//
// Ports
//   clk, rst      system clock, asynchronous active-high reset
//   en            sample-rate enable; all state holds while en=0
//   bpm_value     instantaneous BPM, stable while bpm_valid=1
//   bpm_valid     calculator request, held until bpm_copied
//   bpm_copied    capture acknowledge back to the calculator
//   avg_bpm       smoothed BPM
//   avg_valid     avg_bpm holds a result not yet acknowledged
//   avg_ack       consumer acknowledge, clears avg_valid and overrun
//   out_of_range  one-cycle pulse when a captured reading is rejected
//   no_pulse      timeout expired; cleared by the next accepted reading
//   overrun       sticky: avg_bpm overwritten while still unacknowledged
//   fill_cnt      number of valid entries in the window
//
// Input FSM
//   state   | meaning
//   S_IDLE  | waiting for bpm_valid; latches bpm_value on request
//   S_CHECK | first acknowledge cycle: range check and window update
//   S_HOLD  | acknowledge held until the calculator drops bpm_valid

module bpm_smoother #(
  parameter int DEPTH_LOG2    = 2,
  parameter int BPM_MIN       = 40,
  parameter int BPM_MAX       = 200,
  parameter int TIMEOUT_TICKS = 100
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [7:0]            bpm_value,
  input  logic                  bpm_valid,
  output logic                  bpm_copied,
  output logic [7:0]            avg_bpm,
  output logic                  avg_valid,
  input  logic                  avg_ack,
  output logic                  out_of_range,
  output logic                  no_pulse,
  output logic                  overrun,
  output logic [DEPTH_LOG2:0]   fill_cnt
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int SUM_W = 8 + DEPTH_LOG2;
  localparam int TMR_W = $clog2(TIMEOUT_TICKS + 1);

  localparam logic [DEPTH_LOG2:0] FILL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [TMR_W-1:0]    TMR_LOAD  = TMR_W'(TIMEOUT_TICKS);
  localparam logic [7:0]          MIN_BPM   = 8'(BPM_MIN);
  localparam logic [7:0]          MAX_BPM   = 8'(BPM_MAX);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic                    capture;
  logic                    accept;
  logic                    in_range;

  logic [7:0]              sample_q;
  logic [7:0]              win_q [DEPTH];
  logic [DEPTH_LOG2-1:0]   wr_ptr;
  logic [SUM_W-1:0]        sum_q;
  logic [SUM_W-1:0]        sum_upd;
  logic [7:0]              old_entry;
  logic [DEPTH_LOG2:0]     fill_upd;
  logic                    avg_pend;
  // Down-counter of en ticks left before the pulse is declared lost;
  // reaching zero is the terminal count and it then holds there.
  logic [TMR_W-1:0]        tmr_q;

  assign in_range = (sample_q >= MIN_BPM) && (sample_q <= MAX_BPM);

  // ---------------------------------------------------------------------------
  // Input FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    capture      = 1'b0;
    accept       = 1'b0;
    bpm_copied   = 1'b0;
    out_of_range = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (en && bpm_valid) begin
          capture = 1'b1;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        bpm_copied = 1'b1;
        if (en) begin
          accept       = in_range;
          out_of_range = ~in_range;
          state_d      = bpm_valid ? S_HOLD : S_IDLE;
        end
      end
      S_HOLD: begin
        bpm_copied = 1'b1;
        if (en && !bpm_valid) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Window, running sum, average output and timeout
  // ---------------------------------------------------------------------------
  // Until the window is full the slot being written holds nothing that
  // belongs to the sum, so it contributes zero.
  assign old_entry = (fill_cnt == FILL_FULL) ? win_q[wr_ptr] : 8'd0;
  assign sum_upd   = sum_q + SUM_W'(sample_q) - SUM_W'(old_entry);
  assign fill_upd  = (fill_cnt == FILL_FULL) ? fill_cnt
                                             : fill_cnt + (DEPTH_LOG2 + 1)'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_q  <= 8'd0;
      for (int i = 0; i < DEPTH; i++) begin
        win_q[i] <= 8'd0;
      end
      wr_ptr    <= '0;
      sum_q     <= '0;
      fill_cnt  <= '0;
      avg_pend  <= 1'b0;
      avg_bpm   <= 8'd0;
      avg_valid <= 1'b0;
      overrun   <= 1'b0;
      no_pulse  <= 1'b0;
      tmr_q     <= TMR_LOAD;
    end else if (en) begin
      if (capture) begin
        sample_q <= bpm_value;
      end

      // Average loads one cycle after the window update so it is taken from
      // the registered sum. An ack in the loading cycle consumes the old
      // value, so the new one is not counted as an overwrite.
      if (avg_pend) begin
        avg_bpm   <= sum_q[SUM_W-1:DEPTH_LOG2];
        avg_valid <= 1'b1;
        if (avg_valid && avg_ack) begin
          overrun <= 1'b0;
        end else if (avg_valid) begin
          overrun <= 1'b1;
        end
      end else if (avg_valid && avg_ack) begin
        avg_valid <= 1'b0;
        overrun   <= 1'b0;
      end

      avg_pend <= 1'b0;

      // An accepted reading takes priority over the timeout expiring in the
      // same cycle.
      if (accept) begin
        win_q[wr_ptr] <= sample_q;
        wr_ptr        <= wr_ptr + 1'b1;
        sum_q         <= sum_upd;
        fill_cnt      <= fill_upd;
        avg_pend      <= (fill_upd == FILL_FULL);
        tmr_q         <= TMR_LOAD;
        no_pulse      <= 1'b0;
      end else if (tmr_q != '0) begin
        tmr_q <= tmr_q - TMR_W'(1);
        if (tmr_q == TMR_W'(1)) begin
          no_pulse  <= 1'b1;
          fill_cnt  <= '0;
          sum_q     <= '0;
          wr_ptr    <= '0;
          avg_valid <= 1'b0;
          avg_pend  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_bpm_smoother.sv
module tb_bpm_smoother;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] bpm_value;
  logic       bpm_valid;
  logic       bpm_copied;
  logic [7:0] avg_bpm;
  logic       avg_valid;
  logic       avg_ack;
  logic       out_of_range;
  logic       no_pulse;
  logic       overrun;
  logic [2:0] fill_cnt;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [7:0] win_m[$];
  logic [7:0] exp_q[$];
  logic       avg_v_m = 1'b0;
  logic       ovr_m   = 1'b0;
  logic       np_m    = 1'b0;
  logic [7:0] avg_m   = 8'd0;

  bpm_smoother dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .bpm_value    (bpm_value),
    .bpm_valid    (bpm_valid),
    .bpm_copied   (bpm_copied),
    .avg_bpm      (avg_bpm),
    .avg_valid    (avg_valid),
    .avg_ack      (avg_ack),
    .out_of_range (out_of_range),
    .no_pulse     (no_pulse),
    .overrun      (overrun),
    .fill_cnt     (fill_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] outs_vec();
    return {3'd0, bpm_copied, avg_valid, out_of_range, no_pulse, overrun, avg_bpm};
  endfunction

  // Model: push a reading into the window, queue the expected average if full.
  task automatic model_push(input logic [7:0] v);
    int s;
    win_m.push_back(v);
    if (win_m.size() > 4) void'(win_m.pop_front());
    if (win_m.size() == 4) begin
      s = 0;
      foreach (win_m[i]) s += int'(win_m[i]);
      exp_q.push_back(8'(s / 4));
    end
  endtask

  // Drive one request, wait (bounded) for the acknowledge, then release.
  // Returns at the negedge after release; oor is sampled in the check cycle.
  task automatic send(input logic [7:0] v, output logic oor);
    int n;
    bpm_value = v;
    bpm_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bpm_copied && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("copied_wait", 16'(bpm_copied), 16'd1);
    oor = out_of_range;
    bpm_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_ack();
    avg_ack = 1'b1;
    @(negedge clk);
    avg_ack = 1'b0;
    if (avg_v_m) begin
      avg_v_m = 1'b0;
      ovr_m   = 1'b0;
    end
    chk("ack_valid", 16'(avg_valid), 16'(avg_v_m));
    chk("ack_overrun", 16'(overrun), 16'(ovr_m));
  endtask

  // ack_mode: 0 no ack, 1 ack after the result, 2 ack in the cycle the result loads
  task automatic feed(input logic [7:0] v, input int ack_mode);
    logic oor;
    logic inr;
    logic newavg;
    inr    = (v >= 8'd40) && (v <= 8'd200);
    newavg = 1'b0;
    if (inr) begin
      model_push(v);
      newavg = (win_m.size() == 4);
    end
    send(v, oor);
    chk("oor_pulse", 16'(oor), 16'(!inr));
    chk("oor_end", 16'(out_of_range), 16'd0);
    if (ack_mode == 2) avg_ack = 1'b1;
    @(negedge clk);
    avg_ack = 1'b0;
    if (inr) np_m = 1'b0;
    if (newavg) begin
      if (ack_mode == 2) ovr_m = 1'b0;
      else if (avg_v_m) ovr_m = 1'b1;
      avg_v_m = 1'b1;
      avg_m   = exp_q.pop_front();
    end else if (ack_mode == 2 && avg_v_m) begin
      avg_v_m = 1'b0;
      ovr_m   = 1'b0;
    end
    chk("fill_cnt", 16'(fill_cnt), 16'(win_m.size()));
    chk("avg_valid", 16'(avg_valid), 16'(avg_v_m));
    chk("avg_bpm", 16'(avg_bpm), 16'(avg_m));
    chk("overrun", 16'(overrun), 16'(ovr_m));
    chk("no_pulse", 16'(no_pulse), 16'(np_m));
    if (ack_mode == 1) do_ack();
  endtask

  initial begin
    int cop;
    rst       = 1'b1;
    en        = 1'b1;
    bpm_value = 8'd0;
    bpm_valid = 1'b0;
    avg_ack   = 1'b0;

    // Power-on reset state
    repeat (3) @(negedge clk);
    chk("reset_outs", outs_vec(), 16'd0);
    chk("reset_fill", 16'(fill_cnt), 16'd0);
    rst = 1'b0;
    @(negedge clk);

    // Fill the window; only the fourth reading yields an average (63)
    feed(8'd60, 1);
    feed(8'd62, 1);
    feed(8'd64, 1);
    feed(8'd66, 1);

    // bpm_valid held for 5 cycles with 70: one capture only
    model_push(8'd70);
    bpm_value = 8'd70;
    bpm_valid = 1'b1;
    cop = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bpm_copied) cop++;
    end
    chk("held_copied_cycles", 16'(cop), 16'd5);
    bpm_valid = 1'b0;
    @(negedge clk);
    chk("held_copied_drop", 16'(bpm_copied), 16'd0);
    avg_v_m = 1'b1;
    avg_m   = exp_q.pop_front();
    np_m    = 1'b0;
    chk("held_avg", 16'(avg_bpm), 16'(avg_m));
    chk("held_valid", 16'(avg_valid), 16'd1);
    chk("held_overrun", 16'(overrun), 16'd0);
    chk("held_fill", 16'(fill_cnt), 16'd4);
    do_ack();

    // Range rejects and inclusive bounds
    feed(8'd30, 0);
    feed(8'd210, 0);
    feed(8'd39, 0);
    feed(8'd201, 0);
    feed(8'd200, 1);
    feed(8'd40, 0);

    // Timeout with en toggling: one tick already counted since the accept
    for (int i = 0; i < 98; i++) begin
      en = 1'b0;
      @(negedge clk);
      en = 1'b1;
      @(negedge clk);
    end
    chk("tmo_before_np", 16'(no_pulse), 16'd0);
    chk("tmo_before_fill", 16'(fill_cnt), 16'd4);
    chk("tmo_before_valid", 16'(avg_valid), 16'd1);
    @(negedge clk);
    win_m.delete();
    avg_v_m = 1'b0;
    np_m    = 1'b1;
    chk("tmo_np", 16'(no_pulse), 16'd1);
    chk("tmo_valid", 16'(avg_valid), 16'd0);
    chk("tmo_fill", 16'(fill_cnt), 16'd0);

    // Recovery then overrun accumulation without acks
    feed(8'd72, 0);
    feed(8'd60, 0);
    feed(8'd62, 0);
    feed(8'd64, 0);
    feed(8'd66, 0);
    feed(8'd70, 0);
    chk("ovr_avg65", 16'(avg_bpm), 16'd65);
    do_ack();

    // New average in the same cycle as the ack
    feed(8'd80, 0);
    feed(8'd90, 2);

    do_ack();

    // Reset in the middle of a handshake with a busy window
    feed(8'd100, 0);
    feed(8'd110, 0);
    bpm_value = 8'd120;
    bpm_valid = 1'b1;
    @(negedge clk);
    chk("mid_copied", 16'(bpm_copied), 16'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_outs", outs_vec(), 16'd0);
    chk("async_reset_fill", 16'(fill_cnt), 16'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    win_m.delete();
    exp_q.delete();
    avg_v_m = 1'b0;
    ovr_m   = 1'b0;
    np_m    = 1'b0;
    avg_m   = 8'd0;
    feed(8'd120, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
